// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_pkg / alu_arbiter_if
// Description : Shared ALU types and the bundled requester, external-ALU and
//               response bus of the two-requester ALU arbiter.
//               The master modport is the environment side: requesters,
//               the external combinational ALU and the result consumer.
//               The slave modport is the arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

endpackage

interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  import alu_arbiter_pkg::*;

  // Requester 0
  logic             req0_valid;
  logic             req0_ready;
  alu_op_t          req0_opcode;
  word_t            req0_op1;
  word_t            req0_op2;
  logic [TAG_W-1:0] req0_tag;

  // Requester 1
  logic             req1_valid;
  logic             req1_ready;
  alu_op_t          req1_opcode;
  word_t            req1_op1;
  word_t            req1_op2;
  logic [TAG_W-1:0] req1_tag;

  // Shared external ALU (combinational, outside the arbiter)
  alu_op_t          alu_opcode;
  word_t            alu_op1;
  word_t            alu_op2;
  word_t            alu_out;

  // Result channel
  logic             rsp_valid;
  logic             rsp_ready;
  word_t            rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req0_valid, req0_opcode, req0_op1, req0_op2, req0_tag,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_op1, req1_op2, req1_tag,
    input  req1_ready,
    input  alu_opcode, alu_op1, alu_op2,
    output alu_out,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_op1, req0_op2, req0_tag,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_op1, req1_op2, req1_tag,
    output req1_ready,
    output alu_opcode, alu_op1, alu_op2,
    input  alu_out,
    output rsp_valid, rsp_data, rsp_id, rsp_tag,
    input  rsp_ready
  );

endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Arbitrates two requesters onto one shared combinational ALU
//               and captures the selected result in a one-entry output
//               register (EMPTY/FULL). Sustains one operation per cycle when
//               the consumer drains every cycle.
//               Build option: define ALU_ARBITER_RR_EN for round-robin
//               arbitration; otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  wire logic   clk,
  input  wire logic   reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [31:0]      data_q;
  logic             id_q;
  logic [TAG_W-1:0] tag_q;
  logic             last_q;   // id of the most recent grant

  logic w_can_accept;
  logic w_gnt_any;            // a handshake happens this cycle
  logic w_gnt_id;             // which requester would be granted
  logic w_sel;                // ALU input select, requester 0 when idle

  // Grant decision: one winner per cycle, only when the result slot frees up
  always_comb begin
    w_can_accept = (state_q == EMPTY) | bus.rsp_ready;
    w_gnt_any    = w_can_accept & ~reset & (bus.req0_valid | bus.req1_valid);
`ifdef ALU_ARBITER_RR_EN
    // Alternate when both request; a lone requester always wins.
    if (bus.req0_valid && bus.req1_valid) begin
      w_gnt_id = ~last_q;
    end else if (bus.req0_valid) begin
      w_gnt_id = 1'b0;
    end else if (bus.req1_valid) begin
      w_gnt_id = 1'b1;
    end else begin
      w_gnt_id = last_q;
    end
`else
    // Requester 0 always wins; the pointer only matters when nobody asks,
    // and then w_gnt_any is low so it never reaches a grant.
    if (bus.req0_valid) begin
      w_gnt_id = 1'b0;
    end else if (bus.req1_valid) begin
      w_gnt_id = 1'b1;
    end else begin
      w_gnt_id = last_q;
    end
`endif
    w_sel = w_gnt_any & w_gnt_id;
  end

  assign bus.req0_ready = w_gnt_any & ~w_gnt_id;
  assign bus.req1_ready = w_gnt_any &  w_gnt_id;

  // Operands pass straight through, untouched, from the selected requester
  assign bus.alu_opcode = w_sel ? bus.req1_opcode : bus.req0_opcode;
  assign bus.alu_op1    = w_sel ? bus.req1_op1    : bus.req0_op1;
  assign bus.alu_op2    = w_sel ? bus.req1_op2    : bus.req0_op2;

  // Response comes only from registers; reset masks a stale FULL immediately
  assign bus.rsp_valid  = (state_q == FULL) & ~reset;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_tag    = tag_q;

  // Result register FSM: capture on handshake, drain on rsp_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      data_q  <= '0;
      id_q    <= 1'b0;
      tag_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_gnt_any) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          // A handshake in the same cycle as a drain keeps the slot full.
          if (!w_gnt_any && bus.rsp_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase

      if (w_gnt_any) begin
        data_q <= bus.alu_out;
        id_q   <= w_gnt_id;
        tag_q  <= w_gnt_id ? bus.req1_tag : bus.req0_tag;
        last_q <= w_gnt_id;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed scoreboard bench for alu_arbiter. Stimulus pushes
//               hand-computed results; a negedge monitor pops and compares
//               each response the consumer accepts. The bench models the
//               external combinational ALU. Expectations for the arbitration
//               sequence follow ALU_ARBITER_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic [3:0]  tag;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t mon_e;

  alu_arbiter_if #(.TAG_W(4)) bus_if ();

  alu_arbiter #(.TAG_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (bus_if.alu_opcode)
      ALU_ADD: bus_if.alu_out = bus_if.alu_op1 + bus_if.alu_op2;
      ALU_SUB: bus_if.alu_out = bus_if.alu_op1 - bus_if.alu_op2;
      ALU_AND: bus_if.alu_out = bus_if.alu_op1 & bus_if.alu_op2;
      ALU_OR:  bus_if.alu_out = bus_if.alu_op1 | bus_if.alu_op2;
      ALU_XOR: bus_if.alu_out = bus_if.alu_op1 ^ bus_if.alu_op2;
      ALU_SLL: bus_if.alu_out = bus_if.alu_op1 << bus_if.alu_op2[4:0];
      ALU_SRL: bus_if.alu_out = bus_if.alu_op1 >> bus_if.alu_op2[4:0];
      ALU_SLT: bus_if.alu_out = {31'd0, $signed(bus_if.alu_op1) < $signed(bus_if.alu_op2)};
      default: bus_if.alu_out = 32'd0;
    endcase
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted response must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && bus_if.rsp_valid && bus_if.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: actual data=%0h id=%0d required no response",
                 bus_if.rsp_data, bus_if.rsp_id);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_data", bus_if.rsp_data, mon_e.data);
        chk("rsp_id",   {31'd0, bus_if.rsp_id}, {31'd0, mon_e.id});
        chk("rsp_tag",  {28'd0, bus_if.rsp_tag}, {28'd0, mon_e.tag});
      end
    end
  end

  task automatic drive0(logic v, alu_op_t op, logic [31:0] a, logic [31:0] b, logic [3:0] t);
    bus_if.req0_valid  = v;
    bus_if.req0_opcode = op;
    bus_if.req0_op1    = a;
    bus_if.req0_op2    = b;
    bus_if.req0_tag    = t;
  endtask

  task automatic drive1(logic v, alu_op_t op, logic [31:0] a, logic [31:0] b, logic [3:0] t);
    bus_if.req1_valid  = v;
    bus_if.req1_opcode = op;
    bus_if.req1_op1    = a;
    bus_if.req1_op2    = b;
    bus_if.req1_tag    = t;
  endtask

  // One clock cycle: check readies and rsp_valid mid-cycle, optionally push
  // the expected result of this cycle's handshake, then advance past the edge.
  task automatic cyc(string name, logic e_r0, logic e_r1, logic e_rv,
                     logic push, logic [31:0] d, logic id, logic [3:0] t);
    exp_t e;
    @(negedge clk);
    chk({name, "_req0_ready"}, {31'd0, bus_if.req0_ready}, {31'd0, e_r0});
    chk({name, "_req1_ready"}, {31'd0, bus_if.req1_ready}, {31'd0, e_r1});
    chk({name, "_rsp_valid"},  {31'd0, bus_if.rsp_valid},  {31'd0, e_rv});
    if (push) begin
      e.data = d;
      e.id   = id;
      e.tag  = t;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
    sb.delete();
    reset = 1'b0;
  endtask

  // Arbitration sequence tables: per cycle, both requesters present
  alu_op_t     op0_t[4]  = '{ALU_ADD, ALU_ADD, ALU_AND, ALU_XOR};
  logic [31:0] a0_t[4]   = '{32'd1, 32'd3, 32'hF0, 32'hFF};
  logic [31:0] b0_t[4]   = '{32'd2, 32'd4, 32'h3C, 32'h0F};
  logic [3:0]  t0_t[4]   = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic [31:0] r0_t[4]   = '{32'd3, 32'd7, 32'h30, 32'hF0};
  alu_op_t     op1_t[4]  = '{ALU_SUB, ALU_SUB, ALU_OR, ALU_SUB};
  logic [31:0] a1_t[4]   = '{32'd50, 32'd60, 32'h0F, 32'd0};
  logic [31:0] b1_t[4]   = '{32'd8, 32'd9, 32'h30, 32'd1};
  logic [3:0]  t1_t[4]   = '{4'h8, 4'h9, 4'hA, 4'hB};
  logic [31:0] r1_t[4]   = '{32'd42, 32'd51, 32'h3F, 32'hFFFF_FFFF};

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_if.rsp_ready = 1'b0;
    drive0(1'b1, ALU_ADD, 32'd9, 32'd9, 4'h1);
    drive1(1'b1, ALU_SUB, 32'd9, 32'd1, 4'h2);
    @(posedge clk);
    #1;

    // Reset: nobody accepted, nothing presented, registers cleared
    cyc("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
    cyc("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
    reset = 1'b0;
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0, 4'h0);
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'h0);
    cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
    chk("rst_rsp_data", bus_if.rsp_data, 32'd0);
    chk("rst_rsp_id",   {31'd0, bus_if.rsp_id}, 32'd0);
    chk("rst_rsp_tag",  {28'd0, bus_if.rsp_tag}, 32'd0);

    // Single requester 0: ADD 5+7 tag 3
    bus_if.rsp_ready = 1'b1;
    drive0(1'b1, ALU_ADD, 32'd5, 32'd7, 4'h3);
    cyc("single", 1'b1, 1'b0, 1'b0, 1'b1, 32'd12, 1'b0, 4'h3);
    drive0(1'b0, ALU_SUB, 32'hDEAD, 32'hBEEF, 4'hF);
    cyc("single_rsp", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0);
    cyc("single_drained", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);

    // Both requesters every cycle for four cycles, results back-to-back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, op0_t[i], a0_t[i], b0_t[i], t0_t[i]);
      drive1(1'b1, op1_t[i], a1_t[i], b1_t[i], t1_t[i]);
`ifdef ALU_ARBITER_RR_EN
      if ((i % 2) == 0)
        cyc("arb", 1'b1, 1'b0, (i != 0), 1'b1, r0_t[i], 1'b0, t0_t[i]);
      else
        cyc("arb", 1'b0, 1'b1, 1'b1, 1'b1, r1_t[i], 1'b1, t1_t[i]);
`else
      cyc("arb", 1'b1, 1'b0, (i != 0), 1'b1, r0_t[i], 1'b0, t0_t[i]);
`endif
    end
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0, 4'h0);
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'h0);
    cyc("arb_tail", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0);
    cyc("arb_drained", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);

    // Backpressure: FULL with rsp_ready low blocks requester 1
    bus_if.rsp_ready = 1'b0;
    drive0(1'b1, ALU_ADD, 32'd20, 32'd22, 4'h5);
    cyc("bp_fill", 1'b1, 1'b0, 1'b0, 1'b1, 32'd42, 1'b0, 4'h5);
    drive0(1'b0, ALU_XOR, 32'hFFFF_FFFF, 32'h1234, 4'hE);
    drive1(1'b1, ALU_SUB, 32'd10, 32'd3, 4'h6);
    for (int i = 0; i < 3; i++) begin
      cyc("bp_stall", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0);
      chk("bp_hold_data", bus_if.rsp_data, 32'd42);
    end
    bus_if.rsp_ready = 1'b1;
    cyc("bp_release", 1'b0, 1'b1, 1'b1, 1'b1, 32'd7, 1'b1, 4'h6);
    chk("bp_new_data", bus_if.rsp_data, 32'd7);
    chk("bp_new_id",   {31'd0, bus_if.rsp_id}, 32'd1);
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'h0);
    cyc("bp_tail", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0);
    cyc("bp_drained", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);

    // Reset right after a handshake discards the in-flight result
    bus_if.rsp_ready = 1'b0;
    drive0(1'b1, ALU_ADD, 32'd1, 32'd1, 4'h2);
    cyc("pre_reset_hs", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
    reset = 1'b1;
    bus_if.rsp_ready = 1'b1;
    drive0(1'b1, ALU_ADD, 32'd100, 32'd23, 4'h7);
    drive1(1'b1, ALU_SUB, 32'd9, 32'd4, 4'hC);
    cyc("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
    sb.delete();
    reset = 1'b0;
    cyc("post_reset", 1'b1, 1'b0, 1'b0, 1'b1, 32'd123, 1'b0, 4'h7);
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0, 4'h0);
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0, 4'h0);
    cyc("post_reset_rsp", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0);
    cyc("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the requester tag returned with each result.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  operation from requester n accepted this cycle.
REQ-006 SHALL have ports req0_opcode/req1_opcode  input  alu_op_t  ALU operation.
REQ-007 SHALL have ports req0_op1/req1_op1, req0_op2/req1_op2  input  word_t (32)  operands.
REQ-008 SHALL have ports req0_tag/req1_tag  input  TAG_W  requester tag.
REQ-009 SHALL have ports alu_opcode output alu_op_t, alu_op1/alu_op2 output 32, alu_out input 32  drive/observe the shared external ALU (combinational).
REQ-010 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_data output 32, rsp_id output 1 (granted requester), rsp_tag output TAG_W.

Function
REQ-011 SHALL hold one-entry result register (full flag, data, id, tag); states EMPTY (full=0) and FULL (full=1).
REQ-012 SHALL define can_accept = !full | rsp_ready.
REQ-013 SHALL grant at most one requester per cycle, only when can_accept=1; req*_ready=0 for both when can_accept=0.
REQ-014 SHALL drive alu_opcode/op1/op2 from the granted requester's inputs; when no grant, drive requester 0's inputs.
REQ-015 SHALL assert reqN_ready only for the granted N, in the same cycle, independent of reqN_ready of the other port; handshake = valid&ready.
REQ-016 SHALL, on handshake, load alu_out, grant id and tag into the result register at the next edge; result latency exactly 1 cycle.
REQ-017 SHALL assert rsp_valid = full; rsp_data/rsp_id/rsp_tag stable while rsp_valid=1 and rsp_ready=0.
REQ-018 SHALL transition EMPTY->FULL on handshake; FULL->EMPTY on rsp_ready without handshake; stay FULL on simultaneous rsp_ready and handshake (new result replaces drained one, sustaining 1 op/cycle).
REQ-019 SHALL never depend combinationally on rsp_ready for rsp_valid/rsp_data (registered outputs).
REQ-020 SHALL keep a last-grant pointer updated only on a handshake to the granted id.
REQ-021 SHALL not alter operands or opcode; alu_out width 32, no truncation/extension.
REQ-022 SHALL ignore reqN_opcode/operands/tag when reqN_valid=0.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, clear full, set last-grant to 1, zero rsp_data, rsp_id, rsp_tag.
REQ-024 SHALL hold req0_ready=req1_ready=0 and rsp_valid=0 during any cycle in which reset=1.
REQ-025 SHALL discard an in-flight result register content when reset asserts mid-operation; no result emitted after reset for pre-reset handshakes.

Configuration
REQ-026 SHALL, with macro ALU_ARBITER_RR_EN defined, arbitrate round-robin: when both valid, grant the requester not equal to last-grant; single valid requester always granted.
REQ-027 SHALL, without ALU_ARBITER_RR_EN, use fixed priority: requester 0 wins whenever req0_valid=1; last-grant pointer still present but unused for selection.

Verification
REQ-028 SHALL verify: single req0 ADD op1=5 op2=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_tag=3.
REQ-029 SHALL verify: both valid every cycle for 4 cycles, RR_EN defined, rsp_ready=1 -> grants 0,1,0,1 (first after reset = 0), four results back-to-back.
REQ-030 SHALL verify: same stimulus without RR_EN -> grants 0,0,0,0; req1_ready stays 0 throughout.
REQ-031 SHALL verify: result FULL, rsp_ready=0 for 3 cycles with req1 SUB 10-3 valid -> req1_ready=0, rsp_data unchanged; rsp_ready=1 -> req1 accepted same cycle, next cycle rsp_data=7, rsp_id=1.
REQ-032 SHALL verify: handshake then reset asserted next cycle for 1 cycle -> rsp_valid=0 after reset, no stale result, first post-reset grant to req0 when both valid.
